// File: rtl/regfile_wb_arbiter_if.sv
// Writeback, issue and register-file write bus of regfile_wb_arbiter.
// The master side drives the requests. The slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int D_BITS = 32,
    parameter int A_BITS = 3
);
    localparam int N_REGS = 2 ** A_BITS;

    logic              alu_valid;
    logic [A_BITS-1:0] alu_addr;
    logic [D_BITS-1:0] alu_data;
    logic              alu_ready;
    logic              lsu_valid;
    logic [A_BITS-1:0] lsu_addr;
    logic [D_BITS-1:0] lsu_data;
    logic              lsu_ready;
    logic              iss_valid;
    logic [A_BITS-1:0] iss_addr;
    logic [A_BITS-1:0] src_op0;
    logic [A_BITS-1:0] src_op1;
    logic              hazard;
    logic [N_REGS-1:0] busy;
    logic              we;
    logic [A_BITS-1:0] addr_w;
    logic [D_BITS-1:0] data;

    modport master (
        output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
               iss_valid, iss_addr, src_op0, src_op1,
        input  alu_ready, lsu_ready, hazard, busy, we, addr_w, data
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
               iss_valid, iss_addr, src_op0, src_op1,
        output alu_ready, lsu_ready, hazard, busy, we, addr_w, data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ALU/LSU writeback arbiter with a registered write stage and a busy scoreboard.
// Define WB_RR_ARB_EN for round-robin arbitration; the default is fixed priority LSU > ALU.
module regfile_wb_arbiter #(
    parameter int D_BITS = 32,
    parameter int A_BITS = 3
) (
    input logic                clk,
    input logic                nrst,
    regfile_wb_arbiter_if.slave wb
);
    localparam int N_REGS = 2 ** A_BITS;

    logic              grant_alu;
    logic              grant_lsu;
    logic              we_reg;
    logic [A_BITS-1:0] addr_w_reg;
    logic [D_BITS-1:0] data_reg;
    logic [N_REGS-1:0] busy_reg;
    logic [N_REGS-1:0] busy_next;

`ifdef WB_RR_ARB_EN
    // rr_last_reg: 0 = ALU won last, 1 = LSU won last; the other one wins a conflict.
    logic rr_last_reg;

    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (wb.alu_valid && wb.lsu_valid) begin
            grant_alu = rr_last_reg;
            grant_lsu = !rr_last_reg;
        end else begin
            grant_alu = wb.alu_valid;
            grant_lsu = wb.lsu_valid;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_last_reg <= 1'b0;
        end else if (grant_lsu) begin
            rr_last_reg <= 1'b1;
        end else if (grant_alu) begin
            rr_last_reg <= 1'b0;
        end
    end
`else
    assign grant_lsu = wb.lsu_valid;
    assign grant_alu = wb.alu_valid && !wb.lsu_valid;
`endif

    assign wb.alu_ready = grant_alu;
    assign wb.lsu_ready = grant_lsu;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            we_reg     <= 1'b0;
            addr_w_reg <= '0;
            data_reg   <= '0;
        end else begin
            we_reg <= grant_alu | grant_lsu;
            if (grant_lsu) begin
                addr_w_reg <= wb.lsu_addr;
                data_reg   <= wb.lsu_data;
            end else if (grant_alu) begin
                addr_w_reg <= wb.alu_addr;
                data_reg   <= wb.alu_data;
            end
        end
    end

    // Set wins over clear: a fresh issue means a newer write is still outstanding.
    generate
        for (genvar gi = 0; gi < N_REGS; gi++) begin : g_busy
            assign busy_next[gi] = (wb.iss_valid && (wb.iss_addr == A_BITS'(gi))) ? 1'b1 :
                                   (we_reg && (addr_w_reg == A_BITS'(gi)))      ? 1'b0 :
                                   busy_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign wb.hazard = busy_reg[wb.src_op0] | busy_reg[wb.src_op1];
    assign wb.busy   = busy_reg;
    assign wb.we     = we_reg;
    assign wb.addr_w = addr_w_reg;
    assign wb.data   = data_reg;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed checks for regfile_wb_arbiter: reset, arbitration, write stage and scoreboard.
module tb_regfile_wb_arbiter;
    logic clk;
    logic nrst;
    int   n_cmp;
    int   n_bad;

    regfile_wb_arbiter_if #(.D_BITS(32), .A_BITS(3)) wb ();

    regfile_wb_arbiter #(.D_BITS(32), .A_BITS(3)) dut (
        .clk  (clk),
        .nrst (nrst),
        .wb   (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "time limit");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nrst = 1'b0;
        wb.alu_valid = 1'b0; wb.alu_addr = '0; wb.alu_data = '0;
        wb.lsu_valid = 1'b0; wb.lsu_addr = '0; wb.lsu_data = '0;
        wb.iss_valid = 1'b0; wb.iss_addr = '0;
        wb.src_op0 = '0;     wb.src_op1 = '0;
        #1;
        check("rst_we", wb.we, 0);
        check("rst_addr_w", wb.addr_w, 0);
        check("rst_data", wb.data, 0);
        check("rst_busy", wb.busy, 8'h00);
        step();
        step();
        nrst = 1'b1;
        step();

        // Single ALU write
        wb.alu_valid = 1'b1; wb.alu_addr = 3'd3; wb.alu_data = 32'hDEAD_BEEF;
        #1;
        check("alu_ready", wb.alu_ready, 1);
        check("lsu_ready_idle", wb.lsu_ready, 0);
        step();
        wb.alu_valid = 1'b0;
        check("alu_we", wb.we, 1);
        check("alu_addr_w", wb.addr_w, 3);
        check("alu_data", wb.data, 32'hDEAD_BEEF);
        step();
        check("alu_we_off", wb.we, 0);

        // Conflict: both held until accepted
        wb.alu_valid = 1'b1; wb.alu_addr = 3'd1; wb.alu_data = 32'h11;
        wb.lsu_valid = 1'b1; wb.lsu_addr = 3'd2; wb.lsu_data = 32'h22;
        #1;
        check("cf_lsu_ready", wb.lsu_ready, 1);
        check("cf_alu_ready", wb.alu_ready, 0);
        step();
        check("cf1_we", wb.we, 1);
        check("cf1_addr_w", wb.addr_w, 2);
        check("cf1_data", wb.data, 32'h22);
`ifdef WB_RR_ARB_EN
        // LSU re-requests at once; ALU must win this conflict, then LSU again
        wb.lsu_addr = 3'd6; wb.lsu_data = 32'h66;
        #1;
        check("rr2_alu_ready", wb.alu_ready, 1);
        check("rr2_lsu_ready", wb.lsu_ready, 0);
        step();
        wb.alu_valid = 1'b0;
        check("rr2_we", wb.we, 1);
        check("rr2_addr_w", wb.addr_w, 1);
        wb.alu_valid = 1'b1; wb.alu_addr = 3'd7; wb.alu_data = 32'h77;
        #1;
        check("rr3_lsu_ready", wb.lsu_ready, 1);
        step();
        wb.lsu_valid = 1'b0;
        check("rr3_addr_w", wb.addr_w, 6);
        check("rr3_data", wb.data, 32'h66);
        step();
        wb.alu_valid = 1'b0;
        check("rr4_addr_w", wb.addr_w, 7);
        step();
        check("rr_we_off", wb.we, 0);
`else
        wb.lsu_valid = 1'b0;
        #1;
        check("cf2_alu_ready", wb.alu_ready, 1);
        step();
        wb.alu_valid = 1'b0;
        check("cf2_we", wb.we, 1);
        check("cf2_addr_w", wb.addr_w, 1);
        check("cf2_data", wb.data, 32'h11);
        step();
        check("cf_we_off", wb.we, 0);
`endif

        // Scoreboard set, hazard, clear on writeback
        wb.iss_valid = 1'b1; wb.iss_addr = 3'd5;
        step();
        wb.iss_valid = 1'b0;
        check("sb_busy_set", wb.busy, 8'h20);
        wb.src_op0 = 3'd5; wb.src_op1 = 3'd0;
        #1;
        check("sb_hazard_op0", wb.hazard, 1);
        wb.src_op0 = 3'd1; wb.src_op1 = 3'd5;
        #1;
        check("sb_hazard_op1", wb.hazard, 1);
        wb.src_op0 = 3'd1; wb.src_op1 = 3'd2;
        #1;
        check("sb_hazard_clean", wb.hazard, 0);
        wb.src_op0 = 3'd5;
        wb.lsu_valid = 1'b1; wb.lsu_addr = 3'd5; wb.lsu_data = 32'h55;
        step();
        wb.lsu_valid = 1'b0;
        check("sb_wr_addr_w", wb.addr_w, 5);
        check("sb_busy_pending", wb.busy, 8'h20);
        step();
        check("sb_busy_clear", wb.busy, 8'h00);
        check("sb_hazard_off", wb.hazard, 0);

        // Set/clear collision on reg 4 (write to a non-busy reg)
        wb.alu_valid = 1'b1; wb.alu_addr = 3'd4; wb.alu_data = 32'h44;
        step();
        wb.alu_valid = 1'b0;
        check("col_addr_w", wb.addr_w, 4);
        check("col_busy_before", wb.busy, 8'h00);
        wb.iss_valid = 1'b1; wb.iss_addr = 3'd4;
        step();
        wb.iss_valid = 1'b0;
        check("col_busy_kept", wb.busy, 8'h10);
        step();
        check("col_busy_hold", wb.busy, 8'h10);
        wb.alu_valid = 1'b1;
        step();
        wb.alu_valid = 1'b0;
        step();
        check("col_busy_clear", wb.busy, 8'h00);

`ifndef WB_RR_ARB_EN
        // Stalled loser: three LSU writes while ALU waits
        wb.alu_valid = 1'b1; wb.alu_addr = 3'd7; wb.alu_data = 32'h77;
        for (int k = 0; k < 3; k++) begin
            wb.lsu_valid = 1'b1; wb.lsu_addr = 3'(k); wb.lsu_data = 32'hA0 + 32'(k);
            #1;
            check($sformatf("stall%0d_alu_ready", k), wb.alu_ready, 0);
            step();
            check($sformatf("stall%0d_addr_w", k), wb.addr_w, 64'(k));
            check($sformatf("stall%0d_data", k), wb.data, 64'hA0 + 64'(k));
        end
        wb.lsu_valid = 1'b0;
        #1;
        check("stall_alu_granted", wb.alu_ready, 1);
        step();
        wb.alu_valid = 1'b0;
        check("stall_alu_addr_w", wb.addr_w, 7);
        check("stall_alu_data", wb.data, 32'h77);
        step();
        check("stall_we_off", wb.we, 0);
`endif

        // Asynchronous reset in the middle of a pending write
        wb.iss_valid = 1'b1; wb.iss_addr = 3'd3;
        wb.alu_valid = 1'b1; wb.alu_addr = 3'd6; wb.alu_data = 32'h66;
        step();
        wb.iss_valid = 1'b0; wb.alu_valid = 1'b0;
        check("pre_rst_we", wb.we, 1);
        check("pre_rst_busy", wb.busy, 8'h08);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_we", wb.we, 0);
        check("arst_addr_w", wb.addr_w, 0);
        check("arst_data", wb.data, 0);
        check("arst_busy", wb.busy, 8'h00);
        step();
        nrst = 1'b1;
        step();
        check("post_rst_we", wb.we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
